sv32_ptw_arbiter: RTL and testbench

- Shared Sv32 hardware page table walker for the itlb and the dtlb. Round-robin arbitration between the two miss requesters.
- Walks a two-level page table through a single-outstanding PTE memory port and returns the leaf PTE, a superpage flag, or a page fault to the requesting TLB.
- Sits between the itlb/dtlb miss paths and the L2-side PTE read port.

---
 rtl/sv32_ptw_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sv32_ptw_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw_arbiter.sv
// Shared Sv32 page table walker for the itlb and dtlb. Requests are arbitrated round-robin,
// and the walk issues one PTE read at a time through a single-outstanding memory port.
module sv32_ptw_arbiter #(
    parameter int VPN_WIDTH = 20,
    parameter int PPN_WIDTH = 22,
    parameter int PA_WIDTH  = 34,
    parameter int PTE_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 satp_mode,
    input  logic [PPN_WIDTH-1:0] satp_PPN,
    input  logic                 flush,
    input  logic                 itlb_req_valid,
    input  logic [VPN_WIDTH-1:0] itlb_req_VPN,
    output logic                 itlb_req_ready,
    input  logic                 dtlb_req_valid,
    input  logic [VPN_WIDTH-1:0] dtlb_req_VPN,
    output logic                 dtlb_req_ready,
    output logic                 mem_req_valid,
    output logic [PA_WIDTH-1:0]  mem_req_PA,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [PTE_WIDTH-1:0] mem_resp_PTE,
    output logic                 resp_valid,
    output logic                 resp_requester,
    output logic [VPN_WIDTH-1:0] resp_VPN,
    output logic [PTE_WIDTH-1:0] resp_PTE,
    output logic                 resp_superpage,
    output logic                 resp_page_fault
);
    localparam int VPNH = VPN_WIDTH / 2;

    typedef struct packed {
        logic [PPN_WIDTH-VPNH-1:0] ppn1;
        logic [VPNH-1:0]           ppn0;
        logic [1:0]                rsw;
        logic                      d, a, g, u, x, w, r, v;
    } pte_t;

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DISCARD
    } state_t;

    state_t               state_reg, state_next;
    logic [VPN_WIDTH-1:0] vpn_reg, vpn_next;
    pte_t                 pte_reg, pte_next;
    logic                 id_reg, id_next;
    logic                 fault_reg, fault_next;
    logic                 super_reg, super_next;
    logic                 rr_reg, rr_next;      // requester served last; 1 gives itlb priority
    logic [1:0]           grant;

    pte_t mem_pte;
    logic pte_bad, pte_leaf, leaf_ok;

    assign mem_pte  = mem_resp_PTE;
    assign pte_bad  = !mem_pte.v || (!mem_pte.r && mem_pte.w);
    assign pte_leaf = mem_pte.r || mem_pte.x;
    // A level-1 leaf must be 4MB aligned; a level-0 leaf has no alignment constraint.
    assign leaf_ok  = mem_pte.a && ((state_reg != L1_WAIT) || (mem_pte.ppn0 == '0));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            vpn_reg   <= '0;
            pte_reg   <= '0;
            id_reg    <= 1'b0;
            fault_reg <= 1'b0;
            super_reg <= 1'b0;
            rr_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            vpn_reg   <= vpn_next;
            pte_reg   <= pte_next;
            id_reg    <= id_next;
            fault_reg <= fault_next;
            super_reg <= super_next;
            rr_reg    <= rr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        vpn_next      = vpn_reg;
        pte_next      = pte_reg;
        id_next       = id_reg;
        fault_next    = fault_reg;
        super_next    = super_reg;
        rr_next       = rr_reg;
        grant         = 2'b00;
        mem_req_valid = 1'b0;
        mem_req_PA    = '0;
        resp_valid    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!flush && nRST) begin
                    if (itlb_req_valid && (!dtlb_req_valid || rr_reg))
                        grant = 2'b01;
                    else if (dtlb_req_valid)
                        grant = 2'b10;
                end
                if (grant != 2'b00) begin
                    id_next    = grant[1];
                    vpn_next   = grant[1] ? dtlb_req_VPN : itlb_req_VPN;
                    pte_next   = '0;
                    super_next = 1'b0;
                    fault_next = !satp_mode;
                    state_next = satp_mode ? L1_REQ : RESP;
                end
            end
            L1_REQ, L0_REQ: begin
                mem_req_valid = 1'b1;
                if (state_reg == L1_REQ)
                    mem_req_PA = {satp_PPN, vpn_reg[VPN_WIDTH-1:VPNH], 2'b00};
                else
                    mem_req_PA = {pte_reg.ppn1, pte_reg.ppn0, vpn_reg[VPNH-1:0], 2'b00};
                if (flush)
                    state_next = mem_req_ready ? DISCARD : IDLE;
                else if (mem_req_ready)
                    state_next = (state_reg == L1_REQ) ? L1_WAIT : L0_WAIT;
            end
            L1_WAIT, L0_WAIT: begin
                if (flush) begin
                    state_next = mem_resp_valid ? IDLE : DISCARD;
                end else if (mem_resp_valid) begin
                    pte_next = mem_pte;
                    if (pte_bad || (pte_leaf && !leaf_ok) || (!pte_leaf && state_reg == L0_WAIT)) begin
                        fault_next = 1'b1;
                        state_next = RESP;
                    end else if (pte_leaf) begin
                        super_next = (state_reg == L1_WAIT);
                        state_next = RESP;
                    end else begin
                        state_next = L0_REQ;
                    end
                end
            end
            RESP: begin
                resp_valid = !flush;
                if (!flush)
                    rr_next = id_reg;
                state_next = IDLE;
            end
            DISCARD: begin
                if (mem_resp_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign itlb_req_ready  = grant[0];
    assign dtlb_req_ready  = grant[1];
    assign resp_requester  = resp_valid & id_reg;
    assign resp_VPN        = resp_valid ? vpn_reg : '0;
    assign resp_PTE        = (resp_valid && !fault_reg) ? pte_reg : '0;
    assign resp_superpage  = resp_valid & !fault_reg & super_reg;
    assign resp_page_fault = resp_valid & fault_reg;

endmodule

// File: tb/tb_sv32_ptw_arbiter.sv
// Directed bench for sv32_ptw_arbiter: walks, superpages, faults, arbitration, flush, bare mode
// and reset, with the memory side driven by hand and every expected value written out.
module tb_sv32_ptw_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        satp_mode;
    logic [21:0] satp_PPN;
    logic        flush;
    logic        itlb_req_valid, dtlb_req_valid;
    logic [19:0] itlb_req_VPN, dtlb_req_VPN;
    logic        itlb_req_ready, dtlb_req_ready;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [33:0] mem_req_PA;
    logic [31:0] mem_resp_PTE;
    logic        resp_valid, resp_requester, resp_superpage, resp_page_fault;
    logic [19:0] resp_VPN;
    logic [31:0] resp_PTE;

    int n_checks = 0;
    int n_errors = 0;
    int ready_viol = 0;
    logic prev_ready = 1'b0;

    localparam logic [19:0] VPN_A = 20'h12345;
    localparam logic [19:0] VPN_B = 20'h0ABCD;
    localparam logic [33:0] PA1_A = 34'h0_0001_0120;
    localparam logic [33:0] PA0_A = 34'h0_0002_0D14;
    localparam logic [33:0] PA1_B = 34'h0_0001_00A8;
    localparam logic [33:0] PA0_B = 34'h0_0002_0F34;

    sv32_ptw_arbiter dut (
        .CLK(CLK), .nRST(nRST), .satp_mode(satp_mode), .satp_PPN(satp_PPN), .flush(flush),
        .itlb_req_valid(itlb_req_valid), .itlb_req_VPN(itlb_req_VPN), .itlb_req_ready(itlb_req_ready),
        .dtlb_req_valid(dtlb_req_valid), .dtlb_req_VPN(dtlb_req_VPN), .dtlb_req_ready(dtlb_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_PA(mem_req_PA), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_PTE(mem_resp_PTE),
        .resp_valid(resp_valid), .resp_requester(resp_requester), .resp_VPN(resp_VPN),
        .resp_PTE(resp_PTE), .resp_superpage(resp_superpage), .resp_page_fault(resp_page_fault)
    );

    always #5 CLK = ~CLK;

    // A ready pulse may only appear in IDLE: never alongside a memory request or response,
    // and never on two consecutive cycles.
    always @(negedge CLK) begin
        #3;
        if ((itlb_req_ready || dtlb_req_ready) && (mem_req_valid || resp_valid || prev_ready))
            ready_viol++;
        prev_ready = itlb_req_ready || dtlb_req_ready;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic request(input logic who, input logic [19:0] vpn);
        if (who) begin
            dtlb_req_valid = 1'b1;
            dtlb_req_VPN   = vpn;
        end else begin
            itlb_req_valid = 1'b1;
            itlb_req_VPN   = vpn;
        end
        #1;
        check_eq("req_ready", who ? dtlb_req_ready : itlb_req_ready, 1'b1);
        step();
        itlb_req_valid = 1'b0;
        dtlb_req_valid = 1'b0;
    endtask

    task automatic mem_accept(input logic [33:0] pa, input int stall);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("mem_req_valid", mem_req_valid, 1'b1);
        check_eq("mem_req_lat", n, 0);
        check_eq("mem_req_pa", mem_req_PA, pa);
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("mem_pa_stable", {mem_req_valid, mem_req_PA}, {1'b1, pa});
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check_eq("mem_req_drop", mem_req_valid, 1'b0);
    endtask

    task automatic mem_return(input logic [31:0] pte);
        mem_resp_valid = 1'b1;
        mem_resp_PTE   = pte;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_PTE   = '0;
    endtask

    task automatic expect_resp(input logic who, input logic [19:0] vpn, input logic [31:0] pte,
                               input logic sp, input logic f);
        int n = 0;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("resp_valid", resp_valid, 1'b1);
        check_eq("resp_lat", n, 0);
        check_eq("resp_fields", {resp_requester, resp_VPN, resp_PTE, resp_superpage, resp_page_fault},
                 {who, vpn, pte, sp, f});
        $display("resp: requester=%0d vpn=%05h pte=%08h superpage=%0d fault=%0d",
                 resp_requester, resp_VPN, resp_PTE, resp_superpage, resp_page_fault);
        step();
        check_eq("resp_pulse", resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; satp_mode = 1'b1; satp_PPN = 22'h00010; flush = 1'b0;
        itlb_req_valid = 1'b1; itlb_req_VPN = VPN_A; dtlb_req_valid = 1'b0; dtlb_req_VPN = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_PTE = '0;
        repeat (2) step();
        check_eq("reset_outputs",
                 {itlb_req_ready, dtlb_req_ready, mem_req_valid, mem_req_PA, resp_valid,
                  resp_requester, resp_VPN, resp_PTE, resp_superpage, resp_page_fault}, '0);
        itlb_req_valid = 1'b0;
        nRST = 1'b1;
        step();

        // Arbitration: both requesting continuously; itlb first, then alternating.
        itlb_req_valid = 1'b1; itlb_req_VPN = VPN_A;
        dtlb_req_valid = 1'b1; dtlb_req_VPN = VPN_B;
        for (int w = 0; w < 4; w++) begin
            int n = 0;
            #1;
            while (!(itlb_req_ready || dtlb_req_ready) && n < 20) begin
                step();
                n++;
            end
            check_eq("arb_grant", {itlb_req_ready, dtlb_req_ready}, w[0] ? 2'b01 : 2'b10);
            step();
            mem_accept(w[0] ? PA1_B : PA1_A, 0);
            mem_return(32'h0030004B);
            expect_resp(w[0], w[0] ? VPN_B : VPN_A, 32'h0030004B, 1'b1, 1'b0);
        end
        itlb_req_valid = 1'b0;
        dtlb_req_valid = 1'b0;
        step();

        // Two-level walk.
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00008001);
        mem_accept(PA0_A, 0);
        mem_return(32'h002AF0CB);
        expect_resp(1'b0, VPN_A, 32'h002AF0CB, 1'b0, 1'b0);

        // Superpage with a 5-cycle memory stall, then a misaligned superpage.
        request(1'b1, VPN_A);
        mem_accept(PA1_A, 5);
        mem_return(32'h0030004B);
        expect_resp(1'b1, VPN_A, 32'h0030004B, 1'b1, 1'b0);
        request(1'b1, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h0030044B);
        expect_resp(1'b1, VPN_A, 32'h0, 1'b0, 1'b1);

        // Level-1 faults: invalid, write-only.
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00008000);
        expect_resp(1'b0, VPN_A, 32'h0, 1'b0, 1'b1);
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00000005);
        expect_resp(1'b0, VPN_A, 32'h0, 1'b0, 1'b1);

        // Level-0 faults: non-leaf, leaf with A clear.
        request(1'b1, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00008001);
        mem_accept(PA0_A, 0);
        mem_return(32'h00008001);
        expect_resp(1'b1, VPN_A, 32'h0, 1'b0, 1'b1);
        request(1'b1, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00008001);
        mem_accept(PA0_A, 0);
        mem_return(32'h002AF08B);
        expect_resp(1'b1, VPN_A, 32'h0, 1'b0, 1'b1);

        // Flush in L1_WAIT, response arrives 3 cycles later and is dropped.
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) begin
            step();
            check_eq("discard_quiet", {resp_valid, mem_req_valid}, 2'b00);
        end
        mem_return(32'h002AF0CB);
        check_eq("flush_no_resp", resp_valid, 1'b0);
        request(1'b1, VPN_B);
        mem_accept(PA1_B, 0);
        mem_return(32'h00008001);
        mem_accept(PA0_B, 0);
        mem_return(32'h002AF0CB);
        expect_resp(1'b1, VPN_B, 32'h002AF0CB, 1'b0, 1'b0);

        // Flush in L0_REQ without handshake returns to IDLE the next cycle.
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00008001);
        check_eq("l0_req_valid", mem_req_valid, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("l0_flush_idle", mem_req_valid, 1'b0);
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h0030004B);
        expect_resp(1'b0, VPN_A, 32'h0030004B, 1'b1, 1'b0);

        // Flush in IDLE suppresses the grant.
        itlb_req_valid = 1'b1;
        flush = 1'b1;
        #1;
        check_eq("flush_idle_ready", itlb_req_ready, 1'b0);
        step();
        itlb_req_valid = 1'b0;
        flush = 1'b0;
        check_eq("flush_idle_noreq", mem_req_valid, 1'b0);

        // Bare mode: fault without memory access; then a flush suppressing RESP.
        satp_mode = 1'b0;
        request(1'b1, VPN_B);
        check_eq("bare_no_mem", mem_req_valid, 1'b0);
        expect_resp(1'b1, VPN_B, 32'h0, 1'b0, 1'b1);
        request(1'b0, VPN_A);
        flush = 1'b1;
        #1;
        check_eq("flush_resp_sup", resp_valid, 1'b0);
        step();
        flush = 1'b0;
        check_eq("flush_resp_after", {resp_valid, mem_req_valid}, 2'b00);
        satp_mode = 1'b1;

        // Reset asserted during L0_WAIT.
        request(1'b0, VPN_A);
        mem_accept(PA1_A, 0);
        mem_return(32'h00008001);
        mem_accept(PA0_A, 0);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("rst_mid_outputs",
                 {mem_req_valid, mem_req_PA, resp_valid, resp_VPN, resp_PTE, resp_page_fault}, '0);
        step();
        nRST = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_PTE = 32'h002AF0CB;
        request(1'b1, VPN_B);
        mem_resp_valid = 1'b0;
        mem_resp_PTE = '0;
        mem_accept(PA1_B, 0);
        mem_return(32'h0030004B);
        expect_resp(1'b1, VPN_B, 32'h0030004B, 1'b1, 1'b0);

        step();
        check_eq("ready_outside_idle", ready_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
